// File: rtl/pe_array_drain.sv
// ---------------------------------------------------------------------------
// pe_array_drain
//   Result-readout sequencer for the PE array random-access read port. After
//   a compute pass it walks every PE position in row-major order: drives the
//   address, issues a one-cycle active-low rdn strobe, samples output_value
//   READ_WAIT rising edges later and forwards the word on a valid/ready
//   stream tagged with its row/column.
//
// Optional feature macro: DRAIN_ABORT_EN
//   When defined, adds input abort and output aborted (one-cycle pulse).
//   An abort in any non-idle state drops the drain immediately without done.
//
// Ports
//   master_clock      sole clock
//   reset             synchronous, active-high
//   start             single-cycle request to begin a full drain (IDLE only)
//   busy / done       drain in progress / one-cycle pulse after final beat
//   x_position,
//   y_position        row / column address to array read port
//   rdn               read strobe to array, idle high
//   output_value      array read data
//   out_data/out_row/
//   out_col/out_last  captured beat, valid while out_valid
//   out_valid,
//   out_ready         stream handshake toward result buffer
//   abort, aborted    (DRAIN_ABORT_EN only)
// ---------------------------------------------------------------------------
module pe_array_drain #(
    parameter int ROWS      = 16,
    parameter int COLS      = 16,
    parameter int DATA_W    = 32,
    parameter int READ_WAIT = 2
) (
    input  logic              master_clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [7:0]        x_position,
    output logic [7:0]        y_position,
    output logic              rdn,
    input  logic [DATA_W-1:0] output_value,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        out_row,
    output logic [7:0]        out_col,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
`ifdef DRAIN_ABORT_EN
    ,
    input  logic              abort,
    output logic              aborted
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_WAIT,
        S_PRESENT,
        S_FINISH
    } state_t;

    localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);
    localparam logic [7:0] LAST_COL = 8'(COLS - 1);

    // WAIT lasts READ_WAIT-1 cycles; the counter runs 0 .. READ_WAIT-2.
    localparam int             WCW       = (READ_WAIT > 2) ? $clog2(READ_WAIT - 1) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((READ_WAIT >= 2) ? READ_WAIT - 2 : 0);

    state_t            r_state;
    logic [7:0]        r_row;
    logic [7:0]        r_col;
    logic [WCW-1:0]    r_wait;
    logic              r_busy;
    logic              r_done;
    logic [7:0]        r_x;
    logic [7:0]        r_y;
    logic              r_rdn;
    logic [DATA_W-1:0] r_out_data;
    logic [7:0]        r_out_row;
    logic [7:0]        r_out_col;
    logic              r_out_valid;
    logic              r_out_last;
`ifdef DRAIN_ABORT_EN
    logic              r_aborted;
`endif

    logic       w_sample;
    logic       w_col_wrap;
    logic       w_is_last;
    logic [7:0] w_next_row;
    logic [7:0] w_next_col;

    // The sampling edge is the READ_WAIT-th edge after rdn fell: the edge
    // leaving STROBE when READ_WAIT=1, otherwise the last WAIT edge.
    always_comb begin
        w_sample = 1'b0;
        if (r_state == S_STROBE && READ_WAIT == 1)
            w_sample = 1'b1;
        if (r_state == S_WAIT && r_wait == WAIT_LAST)
            w_sample = 1'b1;
    end

    assign w_col_wrap = (r_col == LAST_COL);
    assign w_is_last  = (r_row == LAST_ROW) && w_col_wrap;
    assign w_next_col = w_col_wrap ? 8'd0 : r_col + 8'd1;
    assign w_next_row = w_col_wrap ? r_row + 8'd1 : r_row;

    always_ff @(posedge master_clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_wait      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_rdn       <= 1'b1;
            r_out_data  <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
`ifdef DRAIN_ABORT_EN
            r_aborted   <= 1'b0;
        end else if (abort && r_state != S_IDLE) begin
            // Abort beats any handshake on the same edge; the beat is lost.
            r_state     <= S_IDLE;
            r_rdn       <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b1;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef DRAIN_ABORT_EN
            r_aborted <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row   <= '0;
                        r_col   <= '0;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                // Address has been stable for one cycle; drop the strobe.
                S_SETUP: begin
                    r_rdn   <= 1'b0;
                    r_state <= S_STROBE;
                end
                S_STROBE: begin
                    r_rdn  <= 1'b1;
                    r_wait <= '0;
                    if (!w_sample)
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!w_sample)
                        r_wait <= r_wait + 1'b1;
                end
                // Outputs hold while stalled; nothing new goes to the array.
                S_PRESENT: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_out_last) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_FINISH;
                        end else begin
                            r_row   <= w_next_row;
                            r_col   <= w_next_col;
                            r_x     <= w_next_row;
                            r_y     <= w_next_col;
                            r_state <= S_SETUP;
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_sample) begin
                r_out_data  <= output_value;
                r_out_row   <= r_row;
                r_out_col   <= r_col;
                r_out_last  <= w_is_last;
                r_out_valid <= 1'b1;
                r_state     <= S_PRESENT;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign x_position = r_x;
    assign y_position = r_y;
    assign rdn        = r_rdn;
    assign out_data   = r_out_data;
    assign out_row    = r_out_row;
    assign out_col    = r_out_col;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
`ifdef DRAIN_ABORT_EN
    assign aborted    = r_aborted;
`endif

endmodule

// File: tb/tb_pe_array_drain.sv
`timescale 1ns/1ps
module tb_pe_array_drain;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]    r;
        logic [7:0]    c;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    typedef struct {
        int            stall;
        logic [7:0]    er;
        logic [7:0]    ec;
        logic [DW-1:0] ed;
        logic          el;
    } vec_t;

    // ---------------- main DUT (defaults, 16x16, READ_WAIT=2) -------------
    logic          start = 1'b0, ordy = 1'b0, ab = 1'b0;
    logic          busy, done, rdn, ovld, olast;
    logic [7:0]    x, y, orow, ocol;
    logic [DW-1:0] ov = '0;
    logic [DW-1:0] od;
`ifdef DRAIN_ABORT_EN
    logic          aborted, aborted2, aborted3;
`endif

    pe_array_drain dut (
        .master_clock(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .x_position(x), .y_position(y), .rdn(rdn), .output_value(ov),
        .out_data(od), .out_row(orow), .out_col(ocol), .out_valid(ovld),
        .out_ready(ordy), .out_last(olast)
`ifdef DRAIN_ABORT_EN
        , .abort(ab), .aborted(aborted)
`endif
    );

    // ---------------- dut2: 2x3, READ_WAIT=3 ------------------------------
    logic          st2 = 1'b0, rdy1 = 1'b1, ab0 = 1'b0;
    logic          busy2, done2, rdn2, ovld2, olast2;
    logic [7:0]    x2, y2, orow2, ocol2;
    logic [DW-1:0] ov2 = '0;
    logic [DW-1:0] od2;

    pe_array_drain #(.ROWS(2), .COLS(3), .DATA_W(DW), .READ_WAIT(3)) dut2 (
        .master_clock(clk), .reset(reset), .start(st2), .busy(busy2), .done(done2),
        .x_position(x2), .y_position(y2), .rdn(rdn2), .output_value(ov2),
        .out_data(od2), .out_row(orow2), .out_col(ocol2), .out_valid(ovld2),
        .out_ready(rdy1), .out_last(olast2)
`ifdef DRAIN_ABORT_EN
        , .abort(ab0), .aborted(aborted2)
`endif
    );

    // ---------------- dut3: 3x1, READ_WAIT=1 ------------------------------
    logic          st3 = 1'b0;
    logic          busy3, done3, rdn3, ovld3, olast3;
    logic [7:0]    x3, y3, orow3, ocol3;
    logic [DW-1:0] ov3 = '0;
    logic [DW-1:0] od3;

    pe_array_drain #(.ROWS(3), .COLS(1), .DATA_W(DW), .READ_WAIT(1)) dut3 (
        .master_clock(clk), .reset(reset), .start(st3), .busy(busy3), .done(done3),
        .x_position(x3), .y_position(y3), .rdn(rdn3), .output_value(ov3),
        .out_data(od3), .out_row(orow3), .out_col(ocol3), .out_valid(ovld3),
        .out_ready(rdy1), .out_last(olast3)
`ifdef DRAIN_ABORT_EN
        , .abort(ab0), .aborted(aborted3)
`endif
    );

    // ---------------- array models: value = row*256 + col ----------------
    // Word becomes valid a fixed time after the falling strobe; garbage before.
    always @(negedge rdn) begin
        logic [7:0] ax, ay;
        ax = x; ay = y;
        ov <= 32'hDEAD_BEEF;
        @(posedge clk);
        ov <= {16'h0, ax, ay};
    end

    always @(negedge rdn2) begin
        logic [7:0] ax, ay;
        ax = x2; ay = y2;
        ov2 <= 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        ov2 <= {16'h0, ax, ay};
    end

    always @(negedge rdn3) ov3 <= {16'h0, x3, y3};

    // ---------------- monitors -------------------------------------------
    beat_t q[$], q2[$], q3[$], cq[$];
    int strobes = 0, done_cnt = 0, rdn_long = 0, hold_err = 0;
    logic rdn_prev_low = 1'b0;
    logic hold_pend = 1'b0;
    logic [66:0] hold_snap = '0;

    always @(posedge clk) begin
        if (reset === 1'b0 && ab === 1'b0 && ovld === 1'b1 && ordy === 1'b1)
            q.push_back({orow, ocol, od, olast});
        if (reset === 1'b0 && ovld2 === 1'b1) q2.push_back({orow2, ocol2, od2, olast2});
        if (reset === 1'b0 && ovld3 === 1'b1) q3.push_back({orow3, ocol3, od3, olast3});
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (rdn === 1'b0 && rdn_prev_low) rdn_long <= rdn_long + 1;
        rdn_prev_low <= (rdn === 1'b0);
        // A stalled beat and the read port must not move on the next cycle.
        if (hold_pend && {ovld, olast, orow, ocol, od, x, y, rdn} !== hold_snap)
            hold_err <= hold_err + 1;
        hold_pend <= (ovld === 1'b1 && ordy === 1'b0 && reset === 1'b0 && ab === 1'b0);
        hold_snap <= {ovld, olast, orow, ocol, od, x, y, rdn};
    end

    always @(negedge rdn) strobes <= strobes + 1;

    // ---------------- helpers --------------------------------------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected stream: every (r,c) in row-major order, data = r*256+c.
    task automatic check_beats(input string tag, input int base, input int R, input int C);
        int k;
        k = 0;
        chk({tag, " beat count"}, 64'(cq.size() - base), 64'(R * C));
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                if (base + k < cq.size()) begin
                    beat_t b;
                    logic  el;
                    b  = cq[base + k];
                    el = (r == R - 1) && (c == C - 1);
                    chk($sformatf("%s beat %0d", tag, k), {b.r, b.c, b.d, b.l},
                        {8'(r), 8'(c), 32'(r * 256 + c), el});
                end
                k++;
            end
    endtask

    task automatic wait_done(input string tag, input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, " done seen"}, done, 1'b1);
    endtask

    task automatic full_drain(input string tag);
        int n, qb, db;
        qb = q.size();
        db = done_cnt;
        ordy = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        wait_done(tag, 1100, n);
        chk({tag, " cycles"}, n, 1024);
        tick();
        chk({tag, " done count"}, done_cnt - db, 1);
        cq = q;
        check_beats(tag, qb, 16, 16);
    endtask

    // ---------------- test sequence --------------------------------------
    initial begin
        vec_t tbl[8];
        int n, qb, sb, db, hb, lb;
        logic [7:0] hx, hy;
        logic pulsed;

        for (int b = 0; b < 8; b++) begin
            tbl[b].stall = (b == 3) ? 5 : ((b == 6) ? 2 : 0);
            tbl[b].er    = 8'd0;
            tbl[b].ec    = 8'(b);
            tbl[b].ed    = 32'(b);
            tbl[b].el    = 1'b0;
        end

        repeat (3) tick();
        chk("rst rdn", rdn, 1'b1);
        chk("rst x", x, 0);
        chk("rst y", y, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst valid", ovld, 0);
        chk("rst last", olast, 0);
        chk("rst data", od, 0);
        chk("rst row", orow, 0);
        chk("rst col", ocol, 0);
        reset = 1'b0;
        tick();

        // READ_WAIT=3, late array data, 2x3 -> 5 cycles per element
        qb = q2.size();
        st2 = 1'b1; tick(); st2 = 1'b0;
        chk("rw3 busy", busy2, 1'b1);
        n = 0;
        while (done2 !== 1'b1 && n < 100) begin tick(); n++; end
        chk("rw3 cycles", n, 30);
        chk("rw3 busy at done", busy2, 0);
        tick();
        cq = q2;
        check_beats("rw3", qb, 2, 3);

        // READ_WAIT=1, single column -> 3 cycles per element
        qb = q3.size();
        st3 = 1'b1; tick(); st3 = 1'b0;
        chk("rw1 busy", busy3, 1'b1);
        n = 0;
        while (done3 !== 1'b1 && n < 100) begin tick(); n++; end
        chk("rw1 cycles", n, 9);
        tick();
        cq = q3;
        check_beats("rw1", qb, 3, 1);

        // Drain A: table-driven backpressure on first beats, then random
        qb = q.size(); sb = strobes; db = done_cnt; hb = hold_err; lb = rdn_long;
        start = 1'b1; tick(); start = 1'b0;
        chk("A busy", busy, 1'b1);
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (ovld !== 1'b1 && n < 50) begin tick(); n++; end
            chk($sformatf("tbl%0d valid", i), ovld, 1'b1);
            chk($sformatf("tbl%0d beat", i), {orow, ocol, od, olast},
                {tbl[i].er, tbl[i].ec, tbl[i].ed, tbl[i].el});
            hx = x; hy = y;
            for (int s = 0; s < tbl[i].stall; s++) begin
                tick();
                chk($sformatf("tbl%0d stall %0d", i, s), {ovld, od, rdn, x, y},
                    {1'b1, tbl[i].ed, 1'b1, hx, hy});
            end
            ordy = 1'b1; tick(); ordy = 1'b0;
            chk($sformatf("tbl%0d hs clears valid", i), ovld, 1'b0);
            chk($sformatf("tbl%0d setup", i), {rdn, x, y}, {1'b1, 8'd0, 8'(i + 1)});
            tick();
            chk($sformatf("tbl%0d strobe", i), rdn, 1'b0);
        end
        n = 0;
        pulsed = 1'b0;
        while (done !== 1'b1 && n < 6000) begin
            ordy = 1'($urandom_range(0, 1));
            if (!pulsed && q.size() - qb == 20) begin start = 1'b1; pulsed = 1'b1; end
            else start = 1'b0;
            tick();
            n++;
        end
        start = 1'b0; ordy = 1'b0;
        chk("A done seen", done, 1'b1);
        chk("A busy at done", busy, 1'b0);
        tick();
        chk("A done one cycle", done, 1'b0);
        repeat (5) tick();
        chk("A done count", done_cnt - db, 1);
        chk("A strobes", strobes - sb, 256);
        chk("A rdn one cycle low", rdn_long - lb, 0);
        chk("A hold stable", hold_err - hb, 0);
        cq = q;
        check_beats("A", qb, 16, 16);

        // Drain B: out_ready always high, exact latency
        full_drain("B");

        // Reset mid-drain at beat 5, held 2 cycles
        qb = q.size(); db = done_cnt;
        ordy = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!(ovld === 1'b1 && q.size() - qb == 5) && n < 100) begin tick(); n++; end
        chk("rstmid beat5 reached", ovld, 1'b1);
        reset = 1'b1; tick();
        chk("rstmid first edge", {rdn, ovld, busy, x, y}, {1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
        tick(); reset = 1'b0;
        repeat (10) tick();
        chk("rstmid no done", done_cnt - db, 0);
        chk("rstmid beat dropped", q.size() - qb, 5);
        chk("rstmid idle", busy, 1'b0);
        full_drain("R");

`ifdef DRAIN_ABORT_EN
        ab = 1'b1; tick(); ab = 1'b0;
        chk("abort idle no pulse", {aborted, busy}, 2'b00);
        qb = q.size(); db = done_cnt;
        ordy = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!(ovld === 1'b1 && q.size() - qb == 10) && n < 100) begin tick(); n++; end
        chk("abort beat10 reached", ovld, 1'b1);
        ab = 1'b1; tick(); ab = 1'b0;
        chk("abort edge", {aborted, ovld, busy, rdn}, 4'b1001);
        chk("abort no handshake", q.size() - qb, 10);
        tick();
        chk("abort pulse one cycle", aborted, 1'b0);
        repeat (10) tick();
        chk("abort no done", done_cnt - db, 0);
        chk("abort side duts", {aborted2, aborted3}, 2'b00);
        full_drain("AB");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_array_drain.md
Name: pe_array_drain

Overview:
Result-readout sequencer for the PE array's random-access read port. After a compute pass, it walks every PE position in row-major order. For each position it drives x_position/y_position, issues a one-cycle active-low rdn strobe, and samples output_value. Each sampled word is forwarded on a valid/ready stream toward the result buffer or host interface.

Parameters:
ROWS, 16, array rows (x_position range), 1..256
COLS, 16, array columns (y_position range), 1..256
DATA_W, 32, width of output_value / out_data
READ_WAIT, 2, rising edges from rdn driven low to output_value sample, >=1

Ports:
master_clock  input  1  sole clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a full drain
busy  output  1  high from accepted start until done pulse
done  output  1  one-cycle pulse after last beat handshakes
x_position  output  8  row index to array read port
y_position  output  8  column index to array read port
rdn  output  1  read strobe to array, idle high; array latches on falling edge
output_value  input  DATA_W  array read data
out_data  output  DATA_W  captured PE value
out_row  output  8  row of out_data
out_col  output  8  column of out_data
out_valid  output  1  out_data/out_row/out_col/out_last valid
out_ready  input  1  downstream accept
out_last  output  1  high with final beat (ROWS-1, COLS-1)

Behaviour:
- Interface: one clock master_clock; reset is synchronous and active-high.
- Reset values: rdn=1, x_position=0, y_position=0, busy=0, done=0, out_valid=0, out_last=0, out_data=0, out_row=0, out_col=0, state IDLE.
- All outputs are registered.
- States: IDLE, SETUP, STROBE, WAIT, PRESENT, FINISH.
- IDLE: when start=1, go to SETUP with row=0, col=0. busy=1 from the next edge.
- start is ignored in every state except IDLE.
- SETUP, 1 cycle: x_position=row, y_position=col, rdn=1. Gives the address one cycle of setup before the strobe.
- STROBE, 1 cycle: rdn=0. rdn returns to 1 on the next edge, so it is low for exactly one cycle.
- WAIT, READ_WAIT-1 cycles; skipped when READ_WAIT=1. rdn=1.
- Sampling: output_value is captured into out_data on the READ_WAIT-th rising edge after rdn goes low. That same edge sets out_valid=1, loads out_row/out_col, and sets out_last when row=ROWS-1 and col=COLS-1.
- PRESENT: out_data, out_row, out_col and out_last are held stable while out_valid=1 and out_ready=0.
- No new address or rdn strobe is issued during backpressure.
- Handshake (out_valid & out_ready) clears out_valid on that edge.
  - If out_last: go to FINISH.
  - Else: advance the index and go to SETUP. Index order is col+1; when col=COLS-1, col wraps to 0 and row increments.
- FINISH, 1 cycle: done=1, busy=0, next state IDLE.
- x_position and y_position keep their last values while idle.
- Throughput with out_ready held high: READ_WAIT+2 cycles per element.
- Full drain: ROWS*COLS*(READ_WAIT+2) cycles from the start edge to the done pulse. Default is 1024.
- Reset mid-drain: all registers return to reset values on the next edge. rdn is forced high, an in-flight beat is dropped, and no done pulse occurs.
- ROWS or COLS = 1 is supported; out_last is then asserted on the appropriate single row or column.

Optional Feature:
DRAIN_ABORT_EN
- Defined: adds input abort (1 bit) and output aborted (1 bit, pulse). abort=1 in any non-IDLE state forces, on that edge: IDLE, rdn=1, out_valid=0, busy=0, aborted=1 for one cycle, and no done. abort has priority over a simultaneous handshake. abort in IDLE does nothing. reset has priority over abort.
- Not defined: neither port exists and behaviour is exactly as above.

Test Plan:
- Reset mid-drain at beat 5, held 2 cycles -> rdn=1, out_valid=0, busy=0 after the first edge; no done. The next start begins again at (0,0).
- Full drain, defaults, array model output_value=row*256+col, out_ready=1 -> 256 beats 0x0000, 0x0001 ... 0x0F0F in order. out_last only on beat 256. Exactly one rdn low per beat. done pulses 1024 cycles after start.
- Backpressure: out_ready=0 for 5 cycles while beat 3 is presented -> out_data=0x0003 stable, rdn stays 1, x_position/y_position unchanged. Beat 4 strobe follows the handshake by 1 cycle.
- start pulsed at beat 20 of a drain -> ignored; beat count stays 256 and a single done pulse occurs.
- READ_WAIT=3 with a model that updates output_value 2 cycles after rdn falls -> every captured value is correct; period is 5 cycles per element.
- DRAIN_ABORT_EN defined, abort at beat 10 with out_valid=1 and out_ready=1 -> aborted pulses, out_valid=0 and no handshake counted, done never fires. A restart drains from (0,0).
